// File: rtl/wb_stage_pkg.sv
// Shared writeback-stage definitions: the PC register index, the default buffer
// depth, the head-of-buffer state codes, the buffered entry layout and a small
// helper that classifies a head entry into its state.
package wb_stage_pkg;

    localparam logic [3:0] REG_PC   = 4'd15;
    localparam int         WB_DEPTH = 2;

    typedef enum logic [1:0] {
        HEAD_IDLE = 2'd0,   // buffer empty
        HEAD_RF   = 2'd1,   // head writes a general register, waits for rf_grant
        HEAD_PC   = 2'd2    // head loads the PC, retires unconditionally
    } head_state_t;

    typedef struct packed {
        logic [3:0]  idx;
        logic [31:0] data;
    } wb_entry_t;

    function automatic head_state_t head_state_of(input logic vld, input logic [3:0] idx);
        if (!vld)
            return HEAD_IDLE;
        return (idx == REG_PC) ? HEAD_PC : HEAD_RF;
    endfunction

endpackage

// File: rtl/wb_stage_fifo.sv
// Purpose: circular writeback buffer holding {idx, data} results in arrival order.
// Latency: a push is visible in the age view the cycle after the edge that writes it.
// Backpressure: push is dropped when full, pop when empty; the owner gates both.
// Ports: clk/rst, push + push_dat, pop, count, age_dat/age_vld (index 0 = oldest).
module wb_fifo
    import wb_stage_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  wb_entry_t              push_dat,
    input  logic                   pop,
    output logic [$clog2(DEPTH):0] count,
    output wb_entry_t              age_dat [DEPTH],
    output logic [DEPTH-1:0]       age_vld
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t     mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok = push && (count != CW'(DEPTH));
    assign pop_ok  = pop  && (count != '0);

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_dat;
    end

    // Present entries by age so the owner never deals with pointer arithmetic.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age_dat[i] = mem[rd_ptr + PW'(i)];
            age_vld[i] = (CW'(i) < count);
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Purpose: writeback stage; buffers results, retires them to the RF or PC, keeps flags.
// Latency: accept at edge N into an empty buffer -> rf_we/pc_load high in cycle N+1.
// Backpressure: ex_ready = buffer not full (no pass-through); RF heads wait for rf_grant.
// Ports: ex_* result in, rf_* register write out, pc_load/pc_value, flag_c/z/n,
//        fwd_idx -> fwd_hit/fwd_data combinational lookup.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [3:0]  ex_rd_idx,
    input  logic [31:0] ex_result,
    input  logic        ex_wr_rd,
    input  logic        ex_S,
    input  logic        ex_carry,
    input  logic        ex_zero,
    input  logic        ex_neg,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    input  logic        rf_grant,
    output logic        pc_load,
    output logic [31:0] pc_value,
    output logic        flag_c,
    output logic        flag_z,
    output logic        flag_n,
    input  logic [3:0]  fwd_idx,
    output logic        fwd_hit,
    output logic [31:0] fwd_data
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]    count;
    wb_entry_t        age_dat [DEPTH];
    logic [DEPTH-1:0] age_vld;
    wb_entry_t        push_dat;
    logic             accept;
    logic             push;
    logic             pop;

    head_state_t state;
    head_state_t state_nxt;
    wb_entry_t   head_nxt;
    logic        head_nxt_vld;
    logic        rf_we_nxt;
    logic        pc_load_nxt;
    logic [3:0]  rf_waddr_nxt;
    logic [31:0] rf_wdata_nxt;
    logic [31:0] pc_value_nxt;

    assign ex_ready = (count < CW'(DEPTH));
    assign accept   = ex_valid && ex_ready;
    assign push     = accept && ex_wr_rd;
    assign push_dat = '{idx: ex_rd_idx, data: ex_result};

    // PC heads retire in their single pc_load cycle; RF heads wait for the grant.
    assign pop = (state == HEAD_PC) || ((state == HEAD_RF) && rf_grant);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .count    (count),
        .age_dat  (age_dat),
        .age_vld  (age_vld)
    );

    // State register: tracks the class of the current buffer head.
    always_ff @(posedge clk) begin
        if (rst)
            state <= HEAD_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state: find what will sit at the head after this edge. A pop exposes
    // the second-oldest entry, or the incoming one if the buffer drains to it.
    always_comb begin
        head_nxt     = '0;
        head_nxt_vld = 1'b0;
        if (pop) begin
            if (age_vld[1]) begin
                head_nxt     = age_dat[1];
                head_nxt_vld = 1'b1;
            end else if (push) begin
                head_nxt     = push_dat;
                head_nxt_vld = 1'b1;
            end
        end else begin
            if (age_vld[0]) begin
                head_nxt     = age_dat[0];
                head_nxt_vld = 1'b1;
            end else if (push) begin
                head_nxt     = push_dat;
                head_nxt_vld = 1'b1;
            end
        end
        state_nxt = head_state_of(head_nxt_vld, head_nxt.idx);
    end

    // Output decode from the next state so the visible outputs are registered.
    always_comb begin
        rf_we_nxt    = 1'b0;
        pc_load_nxt  = 1'b0;
        rf_waddr_nxt = '0;
        rf_wdata_nxt = '0;
        pc_value_nxt = '0;
        case (state_nxt)
            HEAD_RF: begin
                rf_we_nxt    = 1'b1;
                rf_waddr_nxt = head_nxt.idx;
                rf_wdata_nxt = head_nxt.data;
            end
            HEAD_PC: begin
                pc_load_nxt  = 1'b1;
                pc_value_nxt = head_nxt.data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            pc_load  <= 1'b0;
            pc_value <= '0;
        end else begin
            rf_we    <= rf_we_nxt;
            rf_waddr <= rf_waddr_nxt;
            rf_wdata <= rf_wdata_nxt;
            pc_load  <= pc_load_nxt;
            pc_value <= pc_value_nxt;
        end
    end

    // Flags update at accept time, independent of whether an entry is buffered.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_c <= 1'b0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else if (accept && ex_S) begin
            flag_c <= ex_carry;
            flag_z <= ex_zero;
            flag_n <= ex_neg;
        end
    end

    // Scan oldest to youngest so the last match (youngest) wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (age_vld[i] && (age_dat[i].idx == fwd_idx)) begin
                fwd_hit  = 1'b1;
                fwd_data = age_dat[i].data;
            end
        end
    end

endmodule
